bg_rect_renderer: RTL and testbench

BG_RECT_RENDERER -- requirements
Module: bg_rect_renderer

---
 rtl/bg_rect_renderer.sv | 152 +++++++++++++++
 tb/tb_bg_rect_renderer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/bg_rect_renderer.sv
// Background rectangle renderer: a table of enabled rectangles queried per pixel
// through a 2-stage pipeline. The highest matching index wins, and its colour is driven out.

module bg_rect_match #(
  parameter int COORD_W = 9
) (
  input  logic               en,
  input  logic [COORD_W-1:0] x0,
  input  logic [COORD_W-1:0] y0,
  input  logic [COORD_W-1:0] x1,
  input  logic [COORD_W-1:0] y1,
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  output logic               m
);
  // Inverted bounds fail one of the two compares, so they can never match.
  assign m = en && (x >= x0) && (x <= x1) && (y >= y0) && (y <= y1);
endmodule

module bg_rect_renderer #(
  parameter int NUM_RECTS = 16,
  parameter int COORD_W   = 9,
  parameter int COLOUR_W  = 3,
  parameter int BG_COLOUR = 0,
  localparam int IW       = $clog2(NUM_RECTS)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                wr_valid,
  output logic                wr_ready,
  input  logic [IW-1:0]       wr_index,
  input  logic [COORD_W-1:0]  wr_x0,
  input  logic [COORD_W-1:0]  wr_y0,
  input  logic [COORD_W-1:0]  wr_x1,
  input  logic [COORD_W-1:0]  wr_y1,
  input  logic [COLOUR_W-1:0] wr_colour,
  input  logic                wr_enable,
  input  logic                clear_req,
  output logic                busy,
  input  logic                pix_valid,
  input  logic [COORD_W-1:0]  x_cord,
  input  logic [COORD_W-1:0]  y_cord,
  output logic [COLOUR_W-1:0] flag,
  output logic                flag_valid,
  output logic                hit,
  output logic [IW-1:0]       hit_index
);
  localparam logic        IDLE  = 1'b0;
  localparam logic        CLEAR = 1'b1;
  localparam int          STAGES = 2;
  localparam logic [IW-1:0]       LAST = IW'(NUM_RECTS - 1);
  localparam logic [COLOUR_W-1:0] BG   = COLOUR_W'(BG_COLOUR);

  logic                               state;
  logic [IW-1:0]                      clr_idx;
  logic [NUM_RECTS-1:0]               en_q;
  logic [NUM_RECTS-1:0][COORD_W-1:0]  x0_q, y0_q, x1_q, y1_q;
  logic [NUM_RECTS-1:0][COLOUR_W-1:0] col_q;
  logic                               wr_fire;

  assign busy     = (state == CLEAR);
  assign wr_ready = (state == IDLE) && !clear_req;
  // Out-of-range indices are handshaken normally but touch nothing.
  assign wr_fire  = wr_valid && wr_ready && (32'(wr_index) < NUM_RECTS);

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      clr_idx <= '0;
      en_q    <= '0;
    end else if (state == IDLE) begin
      if (clear_req) begin
        state   <= CLEAR;
        clr_idx <= '0;
      end else if (wr_fire) begin
        en_q[wr_index] <= wr_enable;
      end
    end else begin
      en_q[clr_idx] <= 1'b0;
      if (clr_idx == LAST) state <= IDLE;
      else                 clr_idx <= clr_idx + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (wr_fire) begin
      x0_q[wr_index]  <= wr_x0;
      y0_q[wr_index]  <= wr_y0;
      x1_q[wr_index]  <= wr_x1;
      y1_q[wr_index]  <= wr_y1;
      col_q[wr_index] <= wr_colour;
    end
  end

  logic [NUM_RECTS-1:0] match;

  for (genvar i = 0; i < NUM_RECTS; i++) begin : g_match
    bg_rect_match #(.COORD_W(COORD_W)) u_match (
      .en(en_q[i]), .x0(x0_q[i]), .y0(y0_q[i]), .x1(x1_q[i]), .y1(y1_q[i]),
      .x(x_cord), .y(y_cord), .m(match[i])
    );
  end

  // Stage 1 snapshots the colours with the match vector so that a write landing
  // between the two stages cannot leak into a query already in flight.
  logic [STAGES:1]                    vld_pipe;
  logic [NUM_RECTS-1:0]               match_q;
  logic [NUM_RECTS-1:0][COLOUR_W-1:0] col_snap_q;

  always_ff @(posedge clock) begin
    if (reset) vld_pipe <= '0;
    else       vld_pipe <= {vld_pipe[STAGES-1:1], pix_valid};
  end

  always_ff @(posedge clock) begin
    if (pix_valid) begin
      match_q    <= match;
      col_snap_q <= col_q;
    end
  end

  logic                win_hit;
  logic [IW-1:0]       win_idx;
  logic [COLOUR_W-1:0] win_col;

  always_comb begin
    win_hit = 1'b0;
    win_idx = '0;
    win_col = BG;
    for (int i = 0; i < NUM_RECTS; i++) begin
      if (match_q[i]) begin
        win_hit = 1'b1;
        win_idx = IW'(i);
        win_col = col_snap_q[i];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      flag      <= BG;
      hit       <= 1'b0;
      hit_index <= '0;
    end else if (vld_pipe[1]) begin
      flag      <= win_col;
      hit       <= win_hit;
      hit_index <= win_idx;
    end
  end

  assign flag_valid = vld_pipe[STAGES];
endmodule

// File: tb/tb_bg_rect_renderer.sv
// Randomised and directed bench for bg_rect_renderer against a table-level reference model.

module tb_bg_rect_renderer;
  localparam int N  = 16;
  localparam int CW = 9;
  localparam int KW = 3;
  localparam int IW = 4;

  logic clock = 1'b0;
  logic reset, wr_valid, wr_ready, wr_enable, clear_req, busy, pix_valid;
  logic flag_valid, hit;
  logic [IW-1:0] wr_index, hit_index;
  logic [CW-1:0] wr_x0, wr_y0, wr_x1, wr_y1, x_cord, y_cord;
  logic [KW-1:0] wr_colour, flag;

  always #5 clock = ~clock;

  bg_rect_renderer #(.NUM_RECTS(N), .COORD_W(CW), .COLOUR_W(KW), .BG_COLOUR(0)) dut (
    .clock(clock), .reset(reset), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_index(wr_index), .wr_x0(wr_x0), .wr_y0(wr_y0), .wr_x1(wr_x1), .wr_y1(wr_y1),
    .wr_colour(wr_colour), .wr_enable(wr_enable), .clear_req(clear_req), .busy(busy),
    .pix_valid(pix_valid), .x_cord(x_cord), .y_cord(y_cord), .flag(flag),
    .flag_valid(flag_valid), .hit(hit), .hit_index(hit_index)
  );

  typedef struct {
    bit v;
    logic [KW-1:0] f;
    bit h;
    logic [IW-1:0] i;
  } res_t;

  bit            men [N];
  logic [CW-1:0] mx0 [N], my0 [N], mx1 [N], my1 [N];
  logic [KW-1:0] mcol [N];
  int            clear_left, clear_pos;
  res_t          prev, held, cur;
  bit            started;
  int            checks, errors;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d at %0t", nm, got, exp, $time);
    end
  endtask

  // Literal expectations pin both the DUT and the model.
  task automatic lit(input string nm, input logic [31:0] dutv, input logic [31:0] mdl,
                     input logic [31:0] want);
    chk({nm, "_dut"}, dutv, want);
    chk({nm, "_model"}, mdl, want);
  endtask

  function automatic res_t lookup(input logic [CW-1:0] x, input logic [CW-1:0] y);
    res_t r;
    r.v = 1'b1; r.f = '0; r.h = 1'b0; r.i = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (men[k] && mx0[k] <= x && x <= mx1[k] && my0[k] <= y && y <= my1[k]) begin
        r.f = mcol[k]; r.h = 1'b1; r.i = IW'(k);
        break;
      end
    end
    return r;
  endfunction

  task automatic step();
    @(negedge clock);
    if (started) begin
      chk("busy", busy, 32'(clear_left > 0));
      chk("wr_ready", wr_ready, 32'(clear_left == 0 && !clear_req));
    end
    @(posedge clock);
    cur = lookup(x_cord, y_cord);
    cur.v = pix_valid;
    if (reset) begin
      held.v = 0; held.f = '0; held.h = 0; held.i = '0;
      prev.v = 0;
      for (int k = 0; k < N; k++) men[k] = 0;
      clear_left = 0;
      started = 1;
    end else begin
      held.v = prev.v;
      if (prev.v) held = prev;
      prev = cur;
      if (clear_left > 0) begin
        men[clear_pos] = 0;
        clear_pos++;
        clear_left--;
      end else if (clear_req) begin
        clear_left = N;
        clear_pos  = 0;
      end else if (wr_valid && int'(wr_index) < N) begin
        men[wr_index] = wr_enable;
        mx0[wr_index] = wr_x0; my0[wr_index] = wr_y0;
        mx1[wr_index] = wr_x1; my1[wr_index] = wr_y1;
        mcol[wr_index] = wr_colour;
      end
    end
    #1;
    if (started) begin
      chk("flag_valid", flag_valid, 32'(held.v));
      chk("flag", flag, 32'(held.f));
      chk("hit", hit, 32'(held.h));
      chk("hit_index", hit_index, 32'(held.i));
    end
  endtask

  task automatic wr(input int idx, input int x0, input int y0, input int x1, input int y1,
                    input int c, input bit en);
    wr_valid = 1; wr_index = IW'(idx);
    wr_x0 = CW'(x0); wr_y0 = CW'(y0); wr_x1 = CW'(x1); wr_y1 = CW'(y1);
    wr_colour = KW'(c); wr_enable = en;
    step();
    wr_valid = 0;
  endtask

  task automatic q(input int x, input int y);
    pix_valid = 1; x_cord = CW'(x); y_cord = CW'(y);
    step();
    pix_valid = 0;
  endtask

  initial begin
    checks = 0; errors = 0; started = 0; clear_left = 0; clear_pos = 0;
    prev.v = 0; held.v = 0; held.f = '0; held.h = 0; held.i = '0;
    for (int k = 0; k < N; k++) begin
      men[k] = 0; mx0[k] = '0; my0[k] = '0; mx1[k] = '0; my1[k] = '0; mcol[k] = '0;
    end
    reset = 1; wr_valid = 0; wr_index = '0; wr_x0 = '0; wr_y0 = '0; wr_x1 = '0; wr_y1 = '0;
    wr_colour = '0; wr_enable = 0; clear_req = 0; pix_valid = 0; x_cord = '0; y_cord = '0;
    step(); step();
    reset = 0;
    lit("rst_flag_valid", flag_valid, held.v, 0);
    lit("rst_hit", hit, held.h, 0);
    lit("rst_flag", flag, held.f, 0);
    chk("rst_busy", busy, 0);
    chk("rst_wr_ready", wr_ready, 1);

    q(5, 5); step();
    lit("q55_valid", flag_valid, held.v, 1);
    lit("q55_flag", flag, held.f, 0);
    lit("q55_hit", hit, held.h, 0);

    wr(0, 60, 180, 100, 183, 7, 1);
    q(60, 180);
    q(100, 183);
    lit("e0_a", flag, held.f, 7);
    q(101, 183);
    lit("e0_b", flag, held.f, 7);
    q(60, 184);
    lit("e0_c", flag, held.f, 0);
    step();
    lit("e0_d", flag, held.f, 0);
    lit("e0_d_valid", flag_valid, held.v, 1);
    step();
    lit("e0_hold_valid", flag_valid, held.v, 0);

    wr(2, 0, 236, 320, 250, 2, 1);
    wr(5, 8, 0, 33, 511, 7, 1);
    q(10, 240); step();
    lit("ov_flag", flag, held.f, 7);
    lit("ov_idx", hit_index, held.i, 5);
    wr(5, 8, 0, 33, 511, 7, 0);
    q(10, 240); step();
    lit("ov2_flag", flag, held.f, 2);
    lit("ov2_idx", hit_index, held.i, 2);

    wr(3, 50, 0, 40, 511, 6, 1);
    q(45, 100); step();
    lit("inv_hit", hit, held.h, 0);

    for (int k = 0; k < N; k++) wr(k, 0, 0, 511, 511, k % 8, 1);
    q(1, 1); step();
    lit("all_idx", hit_index, held.i, 15);
    clear_req = 1; wr_valid = 1; wr_index = 4; wr_enable = 1; wr_colour = 3;
    step();
    clear_req = 0; wr_valid = 0;
    for (int k = 0; k < N; k++) begin
      chk("clr_busy", busy, 1);
      chk("clr_wr_ready", wr_ready, 0);
      step();
    end
    chk("clr_done_busy", busy, 0);
    q(0, 0); q(200, 300); q(511, 511); step();
    lit("clr_q_flag", flag, held.f, 0);
    lit("clr_q_hit", hit, held.h, 0);

    for (int k = 0; k < N; k++) wr(k, 0, 0, 511, 511, 5, 1);
    clear_req = 1; step(); clear_req = 0;
    for (int k = 0; k < 5; k++) step();
    reset = 1; pix_valid = 1; step(); reset = 0; pix_valid = 0;
    chk("abort_busy", busy, 0);
    chk("abort_wr_ready", wr_ready, 1);
    lit("abort_valid", flag_valid, held.v, 0);
    q(3, 3); step();
    lit("abort_hit", hit, held.h, 0);

    for (int c = 0; c < 1500; c++) begin
      reset     = ($urandom_range(0, 99) == 0);
      clear_req = ($urandom_range(0, 59) == 0);
      wr_valid  = ($urandom_range(0, 2) == 0);
      wr_index  = IW'($urandom_range(0, N - 1));
      wr_x0 = CW'($urandom_range(0, 63)); wr_x1 = CW'($urandom_range(0, 63));
      wr_y0 = CW'($urandom_range(0, 63)); wr_y1 = CW'($urandom_range(0, 63));
      wr_colour = KW'($urandom_range(0, 7));
      wr_enable = ($urandom_range(0, 3) != 0);
      pix_valid = $urandom_range(0, 1);
      x_cord = CW'($urandom_range(0, 63)); y_cord = CW'($urandom_range(0, 63));
      step();
    end
    reset = 0; clear_req = 0; wr_valid = 0; pix_valid = 0;
    step(); step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
